// File: rtl/ccff_stream_loader.sv
// Serial configuration-chain driver: shifts stream words MSB-first onto ccff_head with a
// self-generated prog_clk (clk/2) and returns ccff_tail bits as left-justified readback words.
module ccff_stream_loader #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned LEN_W  = 20
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  chain_len_i,
    input  logic [WORD_W-1:0] s_data_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    output logic              prog_clk_o,
    output logic              ccff_head_o,
    input  logic              ccff_tail_i,
    output logic [WORD_W-1:0] rb_data_o,
    output logic              rb_valid_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned CntW = $clog2(WORD_W) + 1;

    typedef enum logic [2:0] {StIdle, StLoad, StShLo, StShHi, StFin} state_e;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [CntW-1:0]     bitcnt_q, bitcnt_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [WORD_W-1:0]   rbreg_q, rbreg_d;
    logic [WORD_W-1:0]   rb_data_q, rb_data_d;
    logic                rb_valid_q, rb_valid_d;
    logic                head_q, head_d;
    logic                prog_clk_q, prog_clk_d;
    logic                s_ready_q, s_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                last_bit;
    logic                word_end;
    logic [CntW-1:0]     cnt_inc;
    logic [CntW-1:0]     rb_shift;

    assign cnt_inc  = bitcnt_q + CntW'(1);
    assign last_bit = (rem_q == LEN_W'(1));
    assign word_end = (cnt_inc == CntW'(WORD_W));
    // Left-justify the captured bits so a partial word sits in the MSBs.
    assign rb_shift = CntW'(WORD_W) - cnt_inc;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            rem_q      <= '0;
            bitcnt_q   <= '0;
            shreg_q    <= '0;
            rbreg_q    <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
            head_q     <= 1'b0;
            prog_clk_q <= 1'b0;
            s_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            rbreg_q    <= rbreg_d;
            rb_data_q  <= rb_data_d;
            rb_valid_q <= rb_valid_d;
            head_q     <= head_d;
            prog_clk_q <= prog_clk_d;
            s_ready_q  <= s_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = (chain_len_i == '0) ? StFin : StLoad;
                end
            end
            StLoad: begin
                if (s_valid_i && s_ready_q) begin
                    state_d = StShLo;
                end
            end
            StShLo: state_d = StShHi;
            StShHi: begin
                if (last_bit) begin
                    state_d = StFin;
                end else if (word_end) begin
                    state_d = StLoad;
                end else begin
                    state_d = StShLo;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rem_d      = rem_q;
        bitcnt_d   = bitcnt_q;
        shreg_d    = shreg_q;
        rbreg_d    = rbreg_q;
        rb_data_d  = rb_data_q;
        rb_valid_d = 1'b0;
        head_d     = head_q;
        busy_d     = busy_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    rem_d  = chain_len_i;
                    busy_d = 1'b1;
                end
            end
            StLoad: begin
                if (s_valid_i && s_ready_q) begin
                    shreg_d  = s_data_i;
                    bitcnt_d = '0;
                    rbreg_d  = '0;
                    head_d   = s_data_i[WORD_W-1];
                end
            end
            StShLo: begin
                rbreg_d = {rbreg_q[WORD_W-2:0], ccff_tail_i};
            end
            StShHi: begin
                if (rem_q != '0) begin
                    rem_d = rem_q - LEN_W'(1);
                end
                bitcnt_d = cnt_inc;
                shreg_d  = shreg_q << 1;
                head_d   = last_bit ? 1'b0 : shreg_q[WORD_W-2];
                if (last_bit || word_end) begin
                    rb_valid_d = 1'b1;
                    rb_data_d  = rbreg_q << rb_shift;
                end
            end
            StFin: begin
                busy_d = 1'b0;
                head_d = 1'b0;
            end
            default: ;
        endcase
        prog_clk_d = (state_d == StShHi);
        s_ready_d  = (state_d == StLoad);
        done_d     = (state_d == StFin);
    end

    assign s_ready_o   = s_ready_q;
    assign prog_clk_o  = prog_clk_q;
    assign ccff_head_o = head_q;
    assign rb_data_o   = rb_data_q;
    assign rb_valid_o  = rb_valid_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_ccff_stream_loader.sv
// Directed bench for ccff_stream_loader: table of load vectors with a tail loopback
// (optionally inverted) plus hand sequences for zero length, reset mid-shift and stall.
module tb_ccff_stream_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [19:0] chain_len;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        prog_clk;
    logic        head;
    logic        tail;
    logic [31:0] rb_data;
    logic        rb_valid;
    logic        busy;
    logic        done;
    logic        inv;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign tail = head ^ inv;

    ccff_stream_loader #(
        .WORD_W(32),
        .LEN_W (20)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .start_i    (start),
        .chain_len_i(chain_len),
        .s_data_i   (s_data),
        .s_valid_i  (s_valid),
        .s_ready_o  (s_ready),
        .prog_clk_o (prog_clk),
        .ccff_head_o(head),
        .ccff_tail_i(tail),
        .rb_data_o  (rb_data),
        .rb_valid_o (rb_valid),
        .busy_o     (busy),
        .done_o     (done)
    );

    typedef struct packed {
        logic [19:0] len;
        logic [1:0]  nw;
        logic        inv;
        logic [1:0]  nrb;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] r0;
        logic [31:0] r1;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] get_word(input vec_t v, input int i);
        return (i == 0) ? v.w0 : v.w1;
    endfunction

    function automatic logic [31:0] get_rb(input vec_t v, input int i);
        return (i == 0) ? v.r0 : v.r1;
    endfunction

    function automatic logic exp_bit(input vec_t v, input int k);
        logic [31:0] w;
        w = get_word(v, k / 32);
        return w[31 - (k % 32)];
    endfunction

    task automatic run_vec(input vec_t v, input bit stall, input bit poke, input string tag);
        int   idx, nrb, rises, first_rise, done_cyc, sr_rises, gap;
        bit   hs, prev_pc, prev_sr, seen_done, head_bad, gap_bad, busy_bad, stall_done;
        logic gap_head;
        idx = 0; nrb = 0; rises = 0; first_rise = -1; done_cyc = 0; sr_rises = 0; gap = 0;
        hs = 0; prev_pc = 0; prev_sr = 0; seen_done = 0; head_bad = 0; gap_bad = 0;
        busy_bad = 0; stall_done = 0; gap_head = 1'b0;
        inv = v.inv;
        @(negedge clk);
        chain_len = v.len;
        start     = 1'b1;
        s_valid   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
            if (hs) idx++;
            if (!busy) busy_bad = 1;
            if (prog_clk && !prev_pc) begin
                if (first_rise < 0) first_rise = cyc;
                if (rises < 64 && head !== exp_bit(v, rises)) head_bad = 1;
                rises++;
            end
            if (s_ready && !prev_sr) sr_rises++;
            if (rb_valid) begin
                if (nrb < 2) chk({tag, "_rb_word"}, rb_data, get_rb(v, nrb));
                nrb++;
            end
            if (done) begin
                seen_done = 1;
                done_cyc  = cyc;
            end
            if (stall && idx == 1 && s_ready && gap == 0 && !stall_done) begin
                gap      = 10;
                gap_head = head;
            end
            if (gap > 0) begin
                if (prog_clk !== 1'b0 || head !== gap_head) gap_bad = 1;
                gap--;
                if (gap == 0) stall_done = 1;
            end
            s_valid = (idx < int'(v.nw)) && (gap == 0);
            s_data  = s_valid ? get_word(v, idx) : 32'h0;
            if (poke && cyc == 20) begin
                start     = 1'b1;
                chain_len = 20'd3;
            end else begin
                start = 1'b0;
            end
            hs      = s_ready && s_valid;
            prev_pc = prog_clk;
            prev_sr = s_ready;
            @(negedge clk);
        end
        s_valid = 1'b0;
        start   = 1'b0;
        chk({tag, "_done_seen"}, 32'(seen_done), 32'd1);
        chk({tag, "_done_width"}, 32'(done), 32'd0);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        chk({tag, "_busy_during"}, 32'(busy_bad), 32'd0);
        chk({tag, "_prog_rises"}, 32'(rises), 32'(v.len));
        chk({tag, "_rb_count"}, 32'(nrb), 32'(v.nrb));
        chk({tag, "_sready_windows"}, 32'(sr_rises), 32'(v.nw));
        chk({tag, "_head_bits"}, 32'(head_bad), 32'd0);
        if (stall) begin
            chk({tag, "_stall_seen"}, 32'(stall_done), 32'd1);
            chk({tag, "_stall_quiet"}, 32'(gap_bad), 32'd0);
        end else begin
            chk({tag, "_done_latency"}, 32'(done_cyc - first_rise),
                32'(2 * int'(v.len) - 1 + int'(v.nw) - 1));
        end
    endtask

    initial begin
        int rises;
        // len, nw, inv, nrb, w0, w1, r0, r1
        tbl[0] = '{20'd8,  2'd1, 1'b0, 2'd1, 32'hA500_0000, 32'h0, 32'hA500_0000, 32'h0};
        tbl[1] = '{20'd40, 2'd2, 1'b0, 2'd2, 32'h1234_5678, 32'h9A00_0000,
                   32'h1234_5678, 32'h9A00_0000};
        tbl[2] = '{20'd32, 2'd1, 1'b0, 2'd1, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 32'h0};
        tbl[3] = '{20'd12, 2'd1, 1'b1, 2'd1, 32'hF0F1_2345, 32'h0, 32'h0F00_0000, 32'h0};
        tbl[4] = '{20'd33, 2'd2, 1'b0, 2'd2, 32'hAAAA_AAAA, 32'hFFFF_FFFF,
                   32'hAAAA_AAAA, 32'h8000_0000};
        tbl[5] = '{20'd1,  2'd1, 1'b1, 2'd1, 32'h7FFF_FFFF, 32'h0, 32'h8000_0000, 32'h0};
        tbl[6] = '{20'd64, 2'd2, 1'b0, 2'd2, 32'h0123_4567, 32'h89AB_CDEF,
                   32'h0123_4567, 32'h89AB_CDEF};

        reset = 1'b1; start = 1'b0; chain_len = '0; s_data = '0; s_valid = 1'b0; inv = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_prog_clk", 32'(prog_clk), 32'd0);
        chk("rst_head", 32'(head), 32'd0);
        chk("rst_rb_valid", 32'(rb_valid), 32'd0);
        chk("rst_rb_data", rb_data, 32'd0);
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_s_ready", 32'(s_ready), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_vec(tbl[i], 1'b0, 1'b0, $sformatf("vec%0d", i));
        end

        run_vec(tbl[6], 1'b1, 1'b0, "stall");
        run_vec(tbl[1], 1'b0, 1'b1, "restart_ignored");

        // Zero-length load: straight to FIN
        @(negedge clk);
        chain_len = 20'd0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("zero_busy", 32'(busy), 32'd1);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_sready", 32'(s_ready), 32'd0);
        chk("zero_prog_clk", 32'(prog_clk), 32'd0);
        @(negedge clk);
        chk("zero_busy_end", 32'(busy), 32'd0);
        chk("zero_done_end", 32'(done), 32'd0);
        chk("zero_prog_clk_end", 32'(prog_clk), 32'd0);

        // Reset while prog_clk is high for the fifth bit
        inv       = 1'b0;
        chain_len = 20'd16;
        start     = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'hFFFF_0000;
        rises   = 0;
        for (int c = 0; c < 200 && rises < 5; c++) begin
            @(negedge clk);
            if (s_ready == 1'b0) s_valid = 1'b0;
            if (prog_clk) rises++;
        end
        chk("rst_mid_reached", 32'(rises), 32'd5);
        chk("rst_mid_pre_head", 32'(head), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_prog_clk", 32'(prog_clk), 32'd0);
        chk("rst_mid_head", 32'(head), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_sready", 32'(s_ready), 32'd0);
        s_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run_vec(tbl[0], 1'b0, 1'b0, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
